// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming signed multiply-accumulate with one result per frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept a pair (high only while accumulating)
//   in_x       signed operand x (X bits)
//   in_y       signed operand y (Y bits)
//   in_last    this pair closes the frame
//   out_valid  frame result valid
//   out_ready  consumer accepts result
//   acc_out    signed running/frame sum, saturated (ACC bits)
//   overflow   sticky saturation flag for the current frame
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid is high and ready low.
//
// Datapath: S1 registers the operands, the combinational array_multiplier
// forms the product from S1, S2 registers the product, and the accumulator
// adds it one cycle later with saturation at ACC bits.

module array_multiplier #(
    parameter int X = 8,
    parameter int Y = 8
) (
    input  logic signed [X-1:0]   a,
    input  logic signed [Y-1:0]   b,
    output logic signed [X+Y-1:0] p
);
    localparam int P = X + Y;

    logic signed [P-1:0] a_ext;
    logic signed [P-1:0] b_ext;

    always_comb begin
        a_ext = P'(a);
        b_ext = P'(b);
        p     = a_ext * b_ext;
    end
endmodule

module mac_accumulator #(
    parameter int X   = 8,
    parameter int Y   = 8,
    parameter int ACC = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [X-1:0]   in_x,
    input  logic signed [Y-1:0]   in_y,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [ACC-1:0] acc_out,
    output logic                  overflow
);
    localparam int P = X + Y;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [X-1:0]   x_q, x_d;
    logic signed [Y-1:0]   y_q, y_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s1_v_q, s1_v_d;
    logic signed [P-1:0]   prod_q, prod_d;
    logic                  s2_last_q, s2_last_d;
    logic                  s2_v_q, s2_v_d;
    logic signed [ACC-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;

    logic signed [P-1:0]   mul_p;
    logic                  accept;
    logic                  result_taken;
    logic        [ACC:0]   sum;

    localparam logic [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
    localparam logic [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

    array_multiplier #(.X(X), .Y(Y)) u_mul (
        .a (x_q),
        .b (y_q),
        .p (mul_p)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_ACCUM;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last)      state_d = ST_FLUSH;
            ST_FLUSH: if (s2_v_q && s2_last_q)    state_d = ST_DONE;
            ST_DONE:  if (out_ready)              state_d = ST_ACCUM;
            default:                              state_d = ST_ACCUM;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);
    end

    assign accept       = in_valid && in_ready;
    assign result_taken = out_valid && out_ready;

    // ---------------- Datapath next-state ----------------
    always_comb begin
        // S1: capture operands only on an accepted beat
        s1_v_d    = accept;
        x_d       = accept ? in_x    : x_q;
        y_d       = accept ? in_y    : y_q;
        s1_last_d = accept ? in_last : s1_last_q;

        // S2: register product behind a valid S1
        s2_v_d    = s1_v_q;
        prod_d    = s1_v_q ? mul_p     : prod_q;
        s2_last_d = s1_v_q ? s1_last_q : s2_last_q;

        // One extra bit of headroom: the top two bits disagree exactly when
        // the true sum left the ACC-bit signed range.
        sum = {acc_q[ACC-1], acc_q} + {{(ACC+1-P){prod_q[P-1]}}, prod_q};

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (result_taken) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (s2_v_q) begin
            if (sum[ACC] != sum[ACC-1]) begin
                acc_d = sum[ACC] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC-1:0];
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            s1_last_q <= 1'b0;
            s1_v_q    <= 1'b0;
            prod_q    <= '0;
            s2_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            s1_last_q <= s1_last_d;
            s1_v_q    <= s1_v_d;
            prod_q    <= prod_d;
            s2_last_q <= s2_last_d;
            s2_v_q    <= s2_v_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator: directed scenarios plus randomized frames
// checked against a plain-integer reference of the frame sum.

module tb_mac_accumulator;
    localparam int X   = 8;
    localparam int Y   = 8;
    localparam int ACC = 20;
    localparam int ACC_MAX_I = (1 << (ACC-1)) - 1;
    localparam int ACC_MIN_I = -(1 << (ACC-1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                  in_valid;
    logic                  in_ready;
    logic signed [X-1:0]   in_x;
    logic signed [Y-1:0]   in_y;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [ACC-1:0] acc_out;
    logic                  overflow;

    mac_accumulator #(.X(X), .Y(Y), .ACC(ACC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int m_acc;
    bit m_ovf;
    logic [ACC-1:0] exp_q[$];

    function automatic void model_clear();
        m_acc = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_beat(input int x, input int y);
        int s;
        s = m_acc + x * y;
        if (s > ACC_MAX_I) begin s = ACC_MAX_I; m_ovf = 1'b1; end
        if (s < ACC_MIN_I) begin s = ACC_MIN_I; m_ovf = 1'b1; end
        m_acc = s;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one beat and returns 1 time unit after the edge that took it.
    task automatic send_beat(input int x, input int y, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x     = X'(x);
        in_y     = Y'(y);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name, input int exp_acc, input bit exp_ovf);
        int n;
        logic signed [ACC-1:0] e;
        e = ACC'(exp_acc);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
        end
        n_checks++;
        if (acc_out !== e) begin
            n_fail++;
            $display("FAIL %s_acc: acc_out=%0d required %0d", name, acc_out, e);
        end
        n_checks++;
        if (overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s_ovf: overflow=%0b required %0b", name, overflow, exp_ovf);
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || acc_out !== '0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after_hs: out_valid=%0b acc_out=%0d overflow=%0b in_ready=%0b required 0 0 0 1",
                     name, out_valid, acc_out, overflow, in_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; out_ready = 1'b0;
        idle(3);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b acc_out=%0d overflow=%0b required 1 0 0 0",
                     in_ready, out_valid, acc_out, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_beat();
        send_beat(-48, 75, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e0: out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e1: out_valid=%0b required 0", out_valid);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: out_valid=%0b required 1 at E+2", out_valid);
        end
        wait_result("single", -3600, 1'b0);
        handshake("single");
    endtask

    task automatic test_back_to_back();
        send_beat(3, 4, 1'b0);
        send_beat(-5, 6, 1'b0);
        send_beat(127, 127, 1'b0);
        send_beat(-128, 1, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_low: in_ready=%0b required 0", in_ready);
        end
        wait_result("b2b", 15983, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_done: in_ready=%0b required 0", in_ready);
        end
        handshake("b2b");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 32; i++) send_beat(-128, -128, i == 31);
        wait_result("pos_sat", ACC_MAX_I, 1'b1);
        handshake("pos_sat");
        for (int i = 0; i < 33; i++) send_beat(-128, 127, i == 32);
        wait_result("neg_sat", ACC_MIN_I, 1'b1);
        handshake("neg_sat");
        send_beat(1, 1, 1'b1);
        wait_result("after_sat", 1, 1'b0);
        handshake("after_sat");
    endtask

    task automatic test_backpressure();
        logic signed [ACC-1:0] held;
        send_beat(100, 100, 1'b1);
        wait_result("bp", 10000, 1'b0);
        held = acc_out;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_x = X'($urandom_range(0, 255));
            in_y = Y'($urandom_range(0, 255));
            @(negedge clk);
            n_checks++;
            if (acc_out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: acc_out=%0d in_ready=%0b out_valid=%0b required %0d 0 1",
                         acc_out, in_ready, out_valid, held);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("bp");
        send_beat(2, 5, 1'b1);
        wait_result("bp_next", 10, 1'b0);
        handshake("bp_next");
    endtask

    task automatic test_gapped();
        send_beat(10, 10, 1'b0);
        idle(3);
        n_checks++;
        if (acc_out !== 20'sd100) begin
            n_fail++;
            $display("FAIL gap_idle: acc_out=%0d required 100", acc_out);
        end
        send_beat(20, -1, 1'b0);
        idle(1);
        send_beat(-7, -7, 1'b1);
        wait_result("gapped", 129, 1'b0);
        handshake("gapped");
    endtask

    task automatic test_reset_mid_frame();
        send_beat(50, 50, 1'b0);
        send_beat(60, 60, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: in_ready=%0b out_valid=%0b acc_out=%0d overflow=%0b required 1 0 0 0",
                     in_ready, out_valid, acc_out, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        n_checks++;
        if (out_valid !== 1'b0 || acc_out !== '0) begin
            n_fail++;
            $display("FAIL reset_discard: out_valid=%0b acc_out=%0d required 0 0", out_valid, acc_out);
        end
        send_beat(2, 3, 1'b1);
        wait_result("post_reset", 6, 1'b0);
        handshake("post_reset");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int len;
            bit fovf;
            len = $urandom_range(1, 40);
            model_clear();
            for (int b = 0; b < len; b++) begin
                logic signed [X-1:0] x;
                logic signed [Y-1:0] y;
                x = X'($urandom_range(0, 255));
                y = Y'($urandom_range(0, 255));
                // bias some frames toward large same-sign products to reach saturation
                if (f % 3 == 0) begin x = -8'sd120; y = Y'($urandom_range(128, 255)); end
                model_beat(int'(x), int'(y));
                send_beat(int'(x), int'(y), b == len - 1);
                if (b != len - 1) begin
                    in_valid = 1'b0;
                    idle($urandom_range(0, 2));
                end
            end
            exp_q.push_back(ACC'(m_acc));
            fovf = m_ovf;
            wait_result("rand", int'($signed(exp_q.pop_front())), fovf);
            idle($urandom_range(0, 3));
            handshake("rand");
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_gapped();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
